// File: rtl/bsram_pkg.sv
// Shared definitions for the block-RAM request front end and the cache write path.
package bsram_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RMW_READ  = 2'd1,
        RMW_WRITE = 2'd2
    } state_t;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int BYTES = DATA_WIDTH_DEFAULT / 8;
    localparam logic [BYTES-1:0] FULL_MASK = {BYTES{1'b1}};
    localparam logic [BYTES-1:0] ZERO_MASK = {BYTES{1'b0}};

endpackage

// File: rtl/bsram_byte_merge.sv
// Per-byte merge of a new word into an old word under a byte mask.
module bsram_byte_merge
    import bsram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] mask,
    output logic [DATA_WIDTH-1:0]   merged
);

    // Byte i takes the new byte when its mask bit is set.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bsram_rmw_port.sv
// Request front end for the same-cycle-read block RAM: reads, full writes, masked writes.
// Define BSRAM_RMW_PARTIAL_WRITE_EN to run masked writes as a two-cycle read-modify-write.
module bsram_rmw_port
    import bsram_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_byte_en,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    mem_read_enable,
    output logic [ADDR_WIDTH-1:0]   mem_read_address,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    output logic                    mem_write_enable,
    output logic [ADDR_WIDTH-1:0]   mem_write_address,
    output logic [DATA_WIDTH-1:0]   mem_write_data
);

    if ((DATA_WIDTH % 8 != 0) || (CORE < 0)) begin : g_param_check
        $error("bsram_rmw_port: DATA_WIDTH must be a multiple of 8 and CORE non-negative");
    end

    logic                  accept_s;
    logic                  load_resp_s;
    logic                  resp_valid_r;
    logic [DATA_WIDTH-1:0] resp_data_r;

    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;

    // Response holding register: loads on an accepted read, clears on handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
        end else if (load_resp_s) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= mem_read_data;
        end else if (resp_ready) begin
            resp_valid_r <= 1'b0;
        end
    end

`ifdef BSRAM_RMW_PARTIAL_WRITE_EN
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    state_t                state_r;
    state_t                next_state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] old_word_r;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [NUM_BYTES-1:0]  mask_r;
    logic                  latch_req_s;
    logic                  capture_old_s;

    assign req_ready = (state_r == IDLE) && (!resp_valid_r || resp_ready);
    // Gating with reset keeps the RAM ports quiet while reset is held.
    assign accept_s  = req_valid && req_ready && reset;

    bsram_byte_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .old_word(old_word_r),
        .new_word(data_r),
        .mask    (mask_r),
        .merged  (merged_s)
    );

    // State register and the operands of a pending read-modify-write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            data_r     <= '0;
            mask_r     <= '0;
            old_word_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (latch_req_s) begin
                addr_r <= req_address;
                data_r <= req_data;
                mask_r <= req_byte_en;
            end
            if (capture_old_s) begin
                old_word_r <= mem_read_data;
            end
        end
    end

    // Next state and RAM port drive.
    always_comb begin
        next_state_s      = state_r;
        latch_req_s       = 1'b0;
        capture_old_s     = 1'b0;
        load_resp_s       = 1'b0;
        mem_read_enable   = 1'b0;
        mem_read_address  = '0;
        mem_write_enable  = 1'b0;
        mem_write_address = '0;
        mem_write_data    = '0;
        case (state_r)
            IDLE: begin
                if (accept_s && !req_write) begin
                    mem_read_enable  = 1'b1;
                    mem_read_address = req_address;
                    load_resp_s      = 1'b1;
                end else if (accept_s && (&req_byte_en)) begin
                    mem_write_enable  = 1'b1;
                    mem_write_address = req_address;
                    mem_write_data    = req_data;
                end else if (accept_s && (|req_byte_en)) begin
                    latch_req_s  = 1'b1;
                    next_state_s = RMW_READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RMW_READ: begin
                mem_read_enable  = 1'b1;
                mem_read_address = addr_r;
                capture_old_s    = 1'b1;
                next_state_s     = RMW_WRITE;
            end
            RMW_WRITE: begin
                mem_write_enable  = 1'b1;
                mem_write_address = addr_r;
                mem_write_data    = merged_s;
                next_state_s      = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end
`else
    logic unused_byte_en_s;

    assign unused_byte_en_s = ^req_byte_en;
    assign req_ready = !resp_valid_r || resp_ready;
    assign accept_s  = req_valid && req_ready && reset;

    // Every accepted write is a single-cycle full-word write.
    always_comb begin
        load_resp_s       = 1'b0;
        mem_read_enable   = 1'b0;
        mem_read_address  = '0;
        mem_write_enable  = 1'b0;
        mem_write_address = '0;
        mem_write_data    = '0;
        if (accept_s && req_write) begin
            mem_write_enable  = 1'b1;
            mem_write_address = req_address;
            mem_write_data    = req_data;
        end else if (accept_s) begin
            mem_read_enable  = 1'b1;
            mem_read_address = req_address;
            load_resp_s      = 1'b1;
        end else begin
            load_resp_s = 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bsram_rmw_port.sv
// Randomized, model-checked bench for bsram_rmw_port with a behavioural RAM and reference model.
module tb_bsram_rmw_port;
    import bsram_pkg::*;

`ifdef BSRAM_RMW_PARTIAL_WRITE_EN
    localparam bit PARTIAL_EN = 1'b1;
`else
    localparam bit PARTIAL_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_address = 8'h00;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_byte_en = 4'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        mem_read_enable;
    logic [7:0]  mem_read_address;
    logic [31:0] mem_read_data;
    logic        mem_write_enable;
    logic [7:0]  mem_write_address;
    logic [31:0] mem_write_data;

    int checks = 0;
    int errors = 0;

    // RAM with a combinational read port and a clocked write port.
    logic [31:0] ram [0:255] = '{default: 32'h0};
    assign mem_read_data = ram[mem_read_address];
    always @(posedge clock) begin
        if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
    end

    bsram_rmw_port #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data), .req_byte_en(req_byte_en),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // Reference model: expected memory, response register and remaining RMW stall cycles.
    logic [31:0] exp_mem [0:255] = '{default: 32'h0};
    logic        m_resp_v = 1'b0;
    logic [31:0] m_resp_d = 32'h0;
    int          m_busy = 0;
    logic [7:0]  m_addr = 8'h0;
    logic [31:0] m_data = 32'h0;
    logic [3:0]  m_mask = 4'h0;
    logic        e_ready, e_acc, e_re, e_we, e_rd_acc, e_start_pw;
    logic [7:0]  e_ra, e_wa;
    logic [31:0] e_wd;

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_req_ready", req_ready, 1'b1);
            check("rst_resp_valid", resp_valid, 1'b0);
            check("rst_resp_data", resp_data, 32'h0);
            check("rst_mem_ports", {mem_read_enable, mem_read_address, mem_write_enable,
                                    mem_write_address, mem_write_data}, 50'h0);
            m_resp_v = 1'b0;
            m_resp_d = 32'h0;
            m_busy   = 0;
        end else begin
            e_re = 1'b0; e_ra = 8'h0; e_we = 1'b0; e_wa = 8'h0; e_wd = 32'h0;
            e_rd_acc = 1'b0; e_start_pw = 1'b0;
            e_ready = (m_busy == 0) && (!m_resp_v || resp_ready);
            e_acc   = req_valid && e_ready;
            if (m_busy == 2) begin
                e_re = 1'b1; e_ra = m_addr;
            end else if (m_busy == 1) begin
                e_we = 1'b1; e_wa = m_addr; e_wd = merge(exp_mem[m_addr], m_data, m_mask);
            end else if (e_acc && !req_write) begin
                e_re = 1'b1; e_ra = req_address; e_rd_acc = 1'b1;
            end else if (e_acc && (!PARTIAL_EN || req_byte_en == FULL_MASK)) begin
                e_we = 1'b1; e_wa = req_address; e_wd = req_data;
            end else if (e_acc && req_byte_en != ZERO_MASK) begin
                e_start_pw = 1'b1;
            end
            check("req_ready", req_ready, e_ready);
            check("mem_read", {mem_read_enable, mem_read_address}, {e_re, e_ra});
            check("mem_write", {mem_write_enable, mem_write_address, mem_write_data},
                  {e_we, e_wa, e_wd});
            check("resp_valid", resp_valid, m_resp_v);
            check("resp_data", resp_data, m_resp_d);
            if (e_we) exp_mem[e_wa] = e_wd;
            if (e_rd_acc) begin
                m_resp_v = 1'b1;
                m_resp_d = exp_mem[req_address];
            end else if (resp_ready) begin
                m_resp_v = 1'b0;
            end
            if (m_busy != 0) begin
                m_busy = m_busy - 1;
            end else if (e_start_pw) begin
                m_busy = 2; m_addr = req_address; m_data = req_data; m_mask = req_byte_en;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1 got = req_ready;
            @(posedge clock);
            #2;
        end
        req_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got no handshake expected one within 20 cycles");
        end
    endtask

    task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        req_write = w; req_address = a; req_data = d; req_byte_en = be; req_valid = 1'b1;
        wait_accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        reset = 1'b1;
        idle(1);
        // Full write then readback.
        send(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        check("lit_ram10", ram[8'h10], 32'hDEADBEEF);
        send(1'b0, 8'h10, 32'h0, 4'h0);
        check("lit_resp10_v", resp_valid, 1'b1);
        check("lit_resp10_d", resp_data, 32'hDEADBEEF);
        // Masked write into a preloaded word.
        send(1'b1, 8'h20, 32'h11223344, 4'hF);
        send(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101);
        check("lit_rmw_ready0", req_ready, !PARTIAL_EN);
        idle(1);
        check("lit_rmw_ready1", req_ready, !PARTIAL_EN);
        check("lit_rmw_ram_mid", ram[8'h20], PARTIAL_EN ? 32'h11223344 : 32'hAABBCCDD);
        idle(1);
        check("lit_rmw_ready2", req_ready, 1'b1);
        check("lit_rmw_ram", ram[8'h20], PARTIAL_EN ? 32'h11BB33DD : 32'hAABBCCDD);
        send(1'b0, 8'h20, 32'h0, 4'h0);
        check("lit_rmw_resp", resp_data, PARTIAL_EN ? 32'h11BB33DD : 32'hAABBCCDD);
        // Response back-pressure, then a read accepted in the handshake cycle.
        send(1'b1, 8'h30, 32'h30303030, 4'hF);
        resp_ready = 1'b0;
        send(1'b0, 8'h30, 32'h0, 4'h0);
        req_write = 1'b0; req_address = 8'h10; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("lit_bp_ready", req_ready, 1'b0);
            check("lit_bp_data", resp_data, 32'h30303030);
            @(posedge clock);
            #2;
        end
        resp_ready = 1'b1;
        wait_accept();
        check("lit_b2b_v", resp_valid, 1'b1);
        check("lit_b2b_d", resp_data, 32'hDEADBEEF);
        // All-zero mask.
        send(1'b1, 8'h40, 32'h40404040, 4'hF);
        send(1'b1, 8'h40, 32'h12345678, 4'h0);
        idle(2);
        check("lit_zero_mask", ram[8'h40], PARTIAL_EN ? 32'h40404040 : 32'h12345678);
        // Reset in the read phase of a masked write.
        send(1'b1, 8'h50, 32'h55667788, 4'hF);
        send(1'b1, 8'h50, 32'h99AABBCC, 4'b0011);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(2);
        check("lit_rst_ram50", ram[8'h50], PARTIAL_EN ? 32'h55667788 : 32'h99AABBCC);
        check("lit_rst_resp_v", resp_valid, 1'b0);
        // Single-byte mask.
        send(1'b1, 8'h60, 32'hCAFEF00D, 4'b0001);
        check("lit_byte_accept", ram[8'h60], PARTIAL_EN ? 32'h00000000 : 32'hCAFEF00D);
        idle(2);
        check("lit_byte_final", ram[8'h60], PARTIAL_EN ? 32'h0000000D : 32'hCAFEF00D);
        // Random traffic over a small address window, with one reset pulse midway.
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                req_valid = 1'b0;
                reset = 1'b0;
                idle(2);
                reset = 1'b1;
            end
            req_valid   = ($urandom_range(0, 99) < 60);
            req_write   = 1'($urandom_range(0, 1));
            req_address = 8'($urandom_range(0, 15));
            req_data    = $urandom;
            case ($urandom_range(0, 3))
                0:       req_byte_en = FULL_MASK;
                1:       req_byte_en = ZERO_MASK;
                default: req_byte_en = 4'($urandom);
            endcase
            resp_ready = ($urandom_range(0, 99) < 70);
            idle(1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsram_rmw_port.md
# bsram_rmw_port

Request-side front end for the same-cycle-read block RAM. It converts a valid/ready request stream (reads, full-word writes, byte-masked writes) into the RAM's read/write enable ports. Byte-masked writes are executed as a two-cycle read-modify-write. Read data is returned through a registered valid/ready response channel. It sits directly upstream of the RAM, between a core's memory stage or cache and the RAM instance.

## Interface
Parameters:
- CORE, 0: core index carried for debug identification.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, 8: word address width; matches the RAM.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at the rising edge.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- req_byte_en  in  DATA_WIDTH/8  write byte mask; bit i covers bits [8i+7:8i].
- resp_valid  out  1  read data valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_WIDTH  read data.
- mem_read_enable  out  1  to RAM read enable.
- mem_read_address  out  ADDR_WIDTH  to RAM read address.
- mem_read_data  in  DATA_WIDTH  from RAM; combinational, same cycle.
- mem_write_enable  out  1  to RAM write enable.
- mem_write_address  out  ADDR_WIDTH  to RAM write address.
- mem_write_data  out  DATA_WIDTH  to RAM write data.

## Operation
- States: IDLE, RMW_READ, RMW_WRITE.
- req_ready = (state==IDLE) & (!resp_valid | resp_ready). This is combinational, with no dependence on req_valid.
- IDLE, accepted read:
  - Drive mem_read_enable=1 and mem_read_address=req_address in the same cycle.
  - Register mem_read_data into resp_data; set resp_valid.
- IDLE, accepted write with byte_en all ones:
  - Drive mem_write_enable=1 with req_address and req_data in the same cycle.
  - No response is produced.
- IDLE, accepted write with byte_en all zero: no memory activity, no response, stay IDLE.
- IDLE, accepted partial write:
  - Latch address, data and mask; go to RMW_READ. No memory activity in the accept cycle.
- RMW_READ:
  - Drive a read of the latched address; register mem_read_data as old_word.
  - Go to RMW_WRITE.
- RMW_WRITE:
  - Drive mem_write_enable=1 with merged = per byte, mask ? new byte : old_word byte.
  - Go to IDLE.
- Response: resp_valid holds resp_data stable until resp_valid & resp_ready. A new read accepted in the same cycle as that handshake reloads resp_data and keeps resp_valid=1, so back-to-back reads run at 1/cycle.
- The mem_* outputs are 0 whenever they are not driven as above.

## Timing
- Reset values:
  - state=IDLE, resp_valid=0, resp_data=0.
  - All mem_* enables, addresses and data = 0.
  - req_ready=1.
- Read latency: accepted at edge N; resp_valid=1 after edge N.
- Full write: the RAM is updated at the acceptance edge.
- Partial write:
  - Accept at edge N, read at edge N+1, RAM written at edge N+2.
  - req_ready=0 from after edge N until after edge N+2.
  - The next request can be accepted at edge N+3.
- A read that follows a partial write to the same address returns the merged word. This is guaranteed by the stall; no forwarding is needed.
- Reset asserted mid-RMW: the pending write is discarded (no RAM write), state returns to IDLE, and any response is dropped.

## Configuration
- BSRAM_RMW_PARTIAL_WRITE_EN defined: partial-mask behaviour as above.
- Not defined:
  - RMW_READ and RMW_WRITE are removed.
  - req_byte_en is ignored, and every accepted write is a single-cycle full-word write (including an all-zero mask).
  - req_ready depends only on the response channel.

## Structure
- Shared package bsram_pkg holds:
  - state encodings (IDLE=2'd0, RMW_READ=2'd1, RMW_WRITE=2'd2);
  - the BYTES=DATA_WIDTH/8 constant;
  - full-mask / zero-mask constants.
- One sub-module, bsram_byte_merge: combinational per-byte mux (old_word, new_word, mask -> merged). It is reused by the cache write path.

## Test plan
- Reset release, then full write 0xDEADBEEF to addr 0x10 -> mem_write_enable=1 in the accept cycle; a following read of 0x10 gives resp_data=0xDEADBEEF one cycle after accept.
- Preload 0x11223344 at 0x20, then write 0xAABBCCDD with mask 4'b0101 -> req_ready low for 2 cycles; the RAM write occurs 2 cycles after accept with 0x11BB33DD; a read of 0x20 returns 0x11BB33DD.
- Read 0x30 with resp_ready held low for 3 cycles -> resp_valid and resp_data stable; req_ready=0 until resp_ready rises; a new read in the handshake cycle yields back-to-back responses.
- Write with mask 4'b0000 to 0x40 -> no mem_write_enable pulse; contents of 0x40 unchanged on readback.
- Assert reset during RMW_READ of a partial write to 0x50 -> no RAM write; state IDLE; resp_valid=0; 0x50 unchanged.
- Build without BSRAM_RMW_PARTIAL_WRITE_EN, write 0xCAFEF00D with mask 4'b0001 -> full word written in the accept cycle; req_ready never drops.
